// File: rtl/poly_voice_alloc_pkg.sv
// synth_pkg: shared MIDI constants and field widths for the synth voice path
package synth_pkg;
    localparam logic [3:0] DRUM_CH      = 4'd9;
    localparam logic [3:0] MSG_NOTE_ON  = 4'b1001;
    localparam logic [3:0] MSG_NOTE_OFF = 4'b1000;
    localparam logic [3:0] MSG_CC       = 4'b1011;
    localparam logic [6:0] CC_ALL_OFF   = 7'd123;
    localparam int         NW           = 7;
endpackage

// File: rtl/poly_voice_alloc_if.sv
// poly_voice_alloc_if: decoded MIDI strobes in, per-voice gate/note/vel/retrig out
interface poly_voice_alloc_if #(parameter int VOICES = 4);
    import synth_pkg::*;
    logic                   note_on;
    logic                   note_off;
    logic                   all_off;
    logic [3:0]             chan;
    logic [NW-1:0]          note;
    logic [NW-1:0]          vel;
    logic [VOICES-1:0]      gate;
    logic [NW*VOICES-1:0]   voice_note;
    logic [NW*VOICES-1:0]   voice_vel;
    logic [VOICES-1:0]      retrig;
    logic                   dropped;
    modport master (output note_on, note_off, all_off, chan, note, vel,
                    input gate, voice_note, voice_vel, retrig, dropped);
    modport slave  (input note_on, note_off, all_off, chan, note, vel,
                    output gate, voice_note, voice_vel, retrig, dropped);
endinterface

// File: rtl/poly_voice_alloc_voice_pick.sv
// voice_pick: one-hot select of the oldest-ranked candidate voice
module voice_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0]        cand,
    input  logic [N-1:0][W-1:0] rank,
    output logic [N-1:0]        sel,
    output logic                found
);
    // ranks are a permutation, so exactly one candidate survives when any exists
    always_comb begin
        sel = cand;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (cand[j] && rank[j] > rank[i]) sel[i] = 1'b0;
    end
    assign found = |cand;
endmodule

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: LRU polyphonic voice allocator with optional oldest-voice stealing
module poly_voice_alloc
    import synth_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int MIDI_CH = 0,
    parameter int OMNI    = 1,
    parameter int STEAL   = 1
) (
    input logic               clk,
    input logic               rst,
    poly_voice_alloc_if.slave bus
);
    localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [VOICES-1:0]          gate_q, retrig_q, match, g_off, same, sel, free_sel, old_sel;
    logic [VOICES-1:0][NW-1:0]  note_q, vel_q;
    logic [VOICES-1:0][RW-1:0]  rank_q, rank_n;
    logic [RW-1:0]              old_rank;
    logic                       drop_q, acc, ao_v, on_v, off_v, free_found, all_found;

    assign acc   = (bus.chan != DRUM_CH) && (OMNI != 0 || bus.chan == 4'(MIDI_CH));
    assign ao_v  = acc & bus.all_off;
    assign on_v  = acc & bus.note_on & (bus.vel != '0);
    assign off_v = acc & (bus.note_off | (bus.note_on & (bus.vel == '0)));

    for (genvar g = 0; g < VOICES; g++) begin : g_match
        assign match[g] = note_q[g] == bus.note;
    end

    // all_off and note_off land before the note-on looks at the gates
    assign g_off = (ao_v ? '0 : gate_q) & ~(off_v ? match : '0);
    assign same  = g_off & match;

    voice_pick #(.N(VOICES), .W(RW)) u_free (
        .cand(~g_off), .rank(rank_q), .sel(free_sel), .found(free_found)
    );
    voice_pick #(.N(VOICES), .W(RW)) u_old (
        .cand({VOICES{1'b1}}), .rank(rank_q), .sel(old_sel), .found(all_found)
    );

    assign sel = !on_v ? '0 :
                 |same ? same :
                 free_found ? free_sel :
                 (STEAL != 0 && all_found) ? old_sel : '0;

    // assigned voice becomes newest; voices newer than it age by one
    always_comb begin
        old_rank = '0;
        for (int i = 0; i < VOICES; i++)
            if (sel[i]) old_rank = old_rank | rank_q[i];
        for (int i = 0; i < VOICES; i++)
            rank_n[i] = sel[i] ? '0 : (|sel && rank_q[i] < old_rank) ? rank_q[i] + 1'b1 : rank_q[i];
    end

    // voice state registers; note/vel are held after gate drops for release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q   <= '0;
            note_q   <= '0;
            vel_q    <= '0;
            retrig_q <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) rank_q[i] <= RW'(VOICES - 1 - i);
        end else begin
            gate_q   <= g_off | sel;
            retrig_q <= sel;
            drop_q   <= on_v & ~|sel;
            rank_q   <= rank_n;
            for (int i = 0; i < VOICES; i++)
                if (sel[i]) begin
                    note_q[i] <= bus.note;
                    vel_q[i]  <= bus.vel;
                end
        end
    end

    assign bus.gate       = gate_q;
    assign bus.voice_note = note_q;
    assign bus.voice_vel  = vel_q;
    assign bus.retrig     = retrig_q;
    assign bus.dropped    = drop_q;
endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb_poly_voice_alloc: three allocator configs driven in parallel against an LRU-list model
module tb_poly_voice_alloc;
    logic clk = 1'b0;
    logic rst;
    logic s_on, s_off, s_ao;
    logic [3:0] s_ch;
    logic [6:0] s_n, s_v;
    int err = 0, nchk = 0;

    always #5 clk = ~clk;

    poly_voice_alloc_if #(.VOICES(4)) b0 ();
    poly_voice_alloc_if #(.VOICES(4)) b1 ();
    poly_voice_alloc_if #(.VOICES(4)) b2 ();

    poly_voice_alloc #(.VOICES(4), .MIDI_CH(0), .OMNI(1), .STEAL(1)) d0 (.clk(clk), .rst(rst), .bus(b0));
    poly_voice_alloc #(.VOICES(4), .MIDI_CH(0), .OMNI(1), .STEAL(0)) d1 (.clk(clk), .rst(rst), .bus(b1));
    poly_voice_alloc #(.VOICES(4), .MIDI_CH(2), .OMNI(0), .STEAL(1)) d2 (.clk(clk), .rst(rst), .bus(b2));

    assign {b0.note_on, b0.note_off, b0.all_off, b0.chan, b0.note, b0.vel} = {s_on, s_off, s_ao, s_ch, s_n, s_v};
    assign {b1.note_on, b1.note_off, b1.all_off, b1.chan, b1.note, b1.vel} = {s_on, s_off, s_ao, s_ch, s_n, s_v};
    assign {b2.note_on, b2.note_off, b2.all_off, b2.chan, b2.note, b2.vel} = {s_on, s_off, s_ao, s_ch, s_n, s_v};

    logic [3:0]  a_gate[3], a_ret[3];
    logic [27:0] a_note[3], a_vel[3];
    logic        a_drop[3];
    assign {a_gate[0], a_ret[0], a_note[0], a_vel[0], a_drop[0]} = {b0.gate, b0.retrig, b0.voice_note, b0.voice_vel, b0.dropped};
    assign {a_gate[1], a_ret[1], a_note[1], a_vel[1], a_drop[1]} = {b1.gate, b1.retrig, b1.voice_note, b1.voice_vel, b1.dropped};
    assign {a_gate[2], a_ret[2], a_note[2], a_vel[2], a_drop[2]} = {b2.gate, b2.retrig, b2.voice_note, b2.voice_vel, b2.dropped};

    // model: per DUT, gate/note/vel per voice and a usage list ordered oldest..newest
    int steal_p[3] = '{1, 0, 1};
    int omni_p[3]  = '{1, 1, 0};
    int mch_p[3]   = '{0, 0, 2};
    bit mg[3][4], mr[3][4], md[3];
    int mn[3][4], mv[3][4], ord[3][4];

    task automatic m_reset();
        for (int d = 0; d < 3; d++) begin
            md[d] = 0;
            for (int v = 0; v < 4; v++) begin
                mg[d][v] = 0; mr[d][v] = 0; mn[d][v] = 0; mv[d][v] = 0; ord[d][v] = v;
            end
        end
    endtask

    task automatic m_step(int d);
        bit acc, is_on, is_off;
        int k, p;
        acc    = s_ch != 4'd9 && (omni_p[d] != 0 || int'(s_ch) == mch_p[d]);
        is_on  = acc && s_on && s_v != 0;
        is_off = acc && (s_off || (s_on && s_v == 0));
        md[d] = 0;
        for (int v = 0; v < 4; v++) mr[d][v] = 0;
        if (acc && s_ao) for (int v = 0; v < 4; v++) mg[d][v] = 0;
        if (is_off) for (int v = 0; v < 4; v++) if (mg[d][v] && mn[d][v] == int'(s_n)) mg[d][v] = 0;
        if (is_on) begin
            k = -1;
            for (int v = 0; v < 4; v++) if (mg[d][v] && mn[d][v] == int'(s_n)) k = v;
            for (int q = 0; q < 4; q++) if (k < 0 && !mg[d][ord[d][q]]) k = ord[d][q];
            if (k < 0 && steal_p[d] != 0) k = ord[d][0];
            if (k < 0) md[d] = 1;
            else begin
                mg[d][k] = 1; mn[d][k] = int'(s_n); mv[d][k] = int'(s_v); mr[d][k] = 1;
                p = 0;
                for (int q = 0; q < 4; q++) if (ord[d][q] == k) p = q;
                for (int q = p; q < 3; q++) ord[d][q] = ord[d][q+1];
                ord[d][3] = k;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else for (int d = 0; d < 3; d++) m_step(d);
    end

    task automatic chk(string name, int d, logic [27:0] act, logic [27:0] exp);
        nchk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // every falling edge: all outputs of all three DUTs against the model
    always @(negedge clk) begin
        logic [3:0]  eg, er;
        logic [27:0] en, ev;
        for (int d = 0; d < 3; d++) begin
            eg = '0; er = '0; en = '0; ev = '0;
            for (int v = 0; v < 4; v++) begin
                eg[v] = mg[d][v];
                er[v] = mr[d][v];
                en[v*7 +: 7] = 7'(mn[d][v]);
                ev[v*7 +: 7] = 7'(mv[d][v]);
            end
            chk("gate", d, a_gate[d], eg);
            chk("note", d, a_note[d], en);
            chk("vel", d, a_vel[d], ev);
            chk("retrig", d, a_ret[d], er);
            chk("dropped", d, a_drop[d], md[d]);
        end
    end

    task automatic op(bit on, bit off, bit ao, logic [3:0] ch, logic [6:0] n, logic [6:0] v);
        s_on = on; s_off = off; s_ao = ao; s_ch = ch; s_n = n; s_v = v;
        @(posedge clk); #1;
        s_on = 0; s_off = 0; s_ao = 0;
    endtask

    initial begin
        rst = 1; s_on = 0; s_off = 0; s_ao = 0; s_ch = 0; s_n = 0; s_v = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gate", 0, a_gate[0], 0);
        chk("rst_note", 0, a_note[0], 0);
        chk("rst_ret", 0, a_ret[0], 0);
        rst = 0;
        op(1, 0, 0, 0, 60, 100);
        chk("on60_gate", 0, a_gate[0], 4'b0001);
        chk("on60_note", 0, a_note[0][6:0], 60);
        chk("on60_vel", 0, a_vel[0][6:0], 100);
        chk("on60_ret", 0, a_ret[0], 4'b0001);
        op(0, 0, 0, 0, 0, 0);
        chk("ret_pulse", 0, a_ret[0], 0);
        op(1, 0, 0, 0, 62, 100);
        op(1, 0, 0, 0, 64, 100);
        op(1, 0, 0, 0, 65, 100);
        chk("four_gate", 0, a_gate[0], 4'b1111);
        op(1, 0, 0, 0, 67, 100);
        chk("steal_note", 0, a_note[0][6:0], 67);
        chk("steal_gate", 0, a_gate[0], 4'b1111);
        chk("steal_ret", 0, a_ret[0], 4'b0001);
        chk("drop", 1, a_drop[1], 1);
        chk("drop_note", 1, a_note[1][6:0], 60);
        chk("drop_ret", 1, a_ret[1], 0);
        op(1, 1, 0, 0, 62, 0);
        op(0, 1, 0, 0, 62, 0);
        chk("off62_gate", 0, a_gate[0], 4'b1101);
        chk("off62_note", 0, a_note[0][13:7], 62);
        op(1, 0, 0, 0, 69, 100);
        chk("on69_ret", 0, a_ret[0], 4'b0010);
        op(1, 0, 0, 0, 67, 0);
        chk("vel0_gate", 0, a_gate[0], 4'b1110);
        op(1, 0, 0, 0, 67, 80);
        chk("re80_ret", 0, a_ret[0], 4'b0001);
        op(1, 0, 0, 0, 67, 90);
        chk("re90_ret", 0, a_ret[0], 4'b0001);
        chk("re90_vel", 0, a_vel[0][6:0], 90);
        chk("re90_gate", 0, a_gate[0], 4'b1111);
        op(1, 0, 0, 9, 35, 100);
        chk("drum_gate", 0, a_gate[0], 4'b1111);
        chk("drum_ret", 0, a_ret[0], 0);
        op(1, 1, 0, 0, 67, 50);
        chk("offon_ret", 0, a_ret[0], 4'b0001);
        chk("offon_vel", 0, a_vel[0][6:0], 50);
        op(1, 0, 1, 0, 72, 10);
        chk("aoon_gate", 0, a_gate[0], 4'b0100);
        chk("aoon_note", 0, a_note[0][20:14], 72);
        op(0, 0, 1, 0, 0, 0);
        chk("ao_gate", 0, a_gate[0], 0);
        chk("ao_note", 0, a_note[0][6:0], 67);
        op(1, 0, 0, 3, 40, 100);
        chk("ch3_gate", 2, a_gate[2], 0);
        op(1, 0, 0, 2, 41, 100);
        chk("ch2_gate", 2, a_gate[2], 4'b0001);
        chk("ch2_ret", 2, a_ret[2], 4'b0001);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_gate", 0, a_gate[0], 0);
        chk("mid_rst_note", 0, a_note[0], 0);
        rst = 0;
        op(1, 0, 0, 0, 50, 20);
        chk("post_rst_ret", 0, a_ret[0], 4'b0001);
        chk("post_rst_note", 0, a_note[0][6:0], 50);
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] chs [6] = '{0, 0, 2, 2, 3, 9};
            rst   = $urandom_range(0, 399) == 0;
            s_on  = $urandom_range(0, 2) == 0;
            s_off = $urandom_range(0, 3) == 0;
            s_ao  = $urandom_range(0, 39) == 0;
            s_ch  = chs[$urandom_range(0, 5)];
            s_n   = 7'(60 + $urandom_range(0, 7));
            s_v   = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            @(posedge clk); #1;
        end
        rst = 0; s_on = 0; s_off = 0; s_ao = 0;
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err, nchk);
        $finish;
    end
endmodule
